rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (rf_dst_i / rf_dst_d_i / rf_we_i of riscv_rf) between NREQ writeback sources: EX/ALU, LSU load return, and the multi-cycle MUL/DIV/CSR unit.
- Holds a one-entry buffer per source and arbitrates round-robin among them.
- Masks every write during pipeline stalls.
- Keeps a pending-destination scoreboard so decode can detect read-after-write and write-after-write hazards.

---
 rtl/riscv_opcodes_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/rf_wb_arbiter.sv | 112 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_opcodes_pkg.sv
// Shared RISC-V decode types plus the writeback-source map used by the
// register-file write-port arbiter.
package riscv_opcodes_pkg;

  typedef enum logic [4:0] {
    zero, ra, sp, gp, tp, t0, t1, t2,
    s0,   s1, a0, a1, a2, a3, a4, a5,
    a6,   a7, s2, s3, s4, s5, s6, s7,
    s8,   s9, s10, s11, t3, t4, t5, t6
  } rsd_t;

  localparam int WB_NREQ = 3;
  localparam int WB_EX   = 0;
  localparam int WB_LSU  = 1;
  localparam int WB_MDU  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin pick: the first set request at or after ptr_i (wrapping)
// gets a one-hot grant and its index.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o
);

  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req_i[j] && (j == (int'(ptr_i) + i) % N)) begin
          found     = 1'b1;
          gnt_o[j]  = 1'b1;
          gnt_idx_o = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single RF write port among NREQ writeback sources through
// one-entry buffers and round-robin arbitration; tracks pending destinations.
module rf_wb_arbiter
  import riscv_opcodes_pkg::*;
#(
  parameter  int NREQ = WB_NREQ,
  parameter  int XLEN = 32,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  rsd_t [NREQ-1:0]           req_dst_i,
  input  logic [NREQ-1:0][XLEN-1:0] req_data_i,
  input  logic                      rf_hold_i,
  output logic                      rf_we_o,
  output rsd_t                      rf_dst_o,
  output logic [XLEN-1:0]           rf_dst_d_o,
  input  logic                      issue_valid_i,
  input  rsd_t                      issue_dst_i,
  output logic                      issue_ready_o,
  input  rsd_t                      rd_src1_i,
  input  rsd_t                      rd_src2_i,
  output logic                      hazard1_o,
  output logic                      hazard2_o
);

  logic [NREQ-1:0]           full_q, full_d;
  rsd_t [NREQ-1:0]           dst_q, dst_d;
  logic [NREQ-1:0][XLEN-1:0] data_q, data_d;
  logic [31:0]               pending_q, pending_d;
  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]           gnt;
  logic [PW-1:0]             gnt_idx;
  logic                      any_full;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i     (full_q),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Write is also gated by rst_n so buffered data is dropped on reset rather
  // than slipping into the RF on the reset edge.
  always_comb begin
    any_full      = |full_q;
    rf_we_o       = any_full & ~rf_hold_i & rst_n;
    rf_dst_o      = any_full ? dst_q[gnt_idx]  : zero;
    rf_dst_d_o    = any_full ? data_q[gnt_idx] : '0;
    req_ready_o   = ~full_q | (gnt & {NREQ{~rf_hold_i}});
    issue_ready_o = ~pending_q[issue_dst_i] | (issue_dst_i == zero);
    hazard1_o     = (rd_src1_i != zero) & pending_q[rd_src1_i];
    hazard2_o     = (rd_src2_i != zero) & pending_q[rd_src2_i];
  end

  always_comb begin
    full_d = full_q;
    dst_d  = dst_q;
    data_d = data_q;
    for (int s = 0; s < NREQ; s++) begin
      if (gnt[s] && rf_we_o) full_d[s] = 1'b0;
      // x0 writes are acknowledged but never buffered.
      if (req_valid_i[s] && req_ready_o[s] && req_dst_i[s] != zero) begin
        full_d[s] = 1'b1;
        dst_d[s]  = req_dst_i[s];
        data_d[s] = req_data_i[s];
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (rf_we_o) rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

    // Clear before set so a same-cycle reissue keeps the register pending.
    pending_d = pending_q;
    if (rf_we_o) pending_d[rf_dst_o] = 1'b0;
    if (issue_valid_i && issue_ready_o && issue_dst_i != zero) pending_d[issue_dst_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q    <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      full_q    <= full_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < NREQ; s++) begin
        if (req_valid_i[s] && req_ready_o[s] && req_dst_i[s] != zero)
          assert (pending_q[req_dst_i[s]])
            else $error("rf_wb_arbiter: source %0d writes non-pending dst %0d", s, req_dst_i[s]);
        for (int t = s + 1; t < NREQ; t++)
          if (full_q[s] && full_q[t])
            assert (dst_q[s] != dst_q[t])
              else $error("rf_wb_arbiter: buffers %0d and %0d share dst", s, t);
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed checks of rf_wb_arbiter: reset, contention, single write, hold,
// x0 drop, WAW, and reset with buffered writes.
module tb_rf_wb_arbiter;
  import riscv_opcodes_pkg::*;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  rsd_t [NREQ-1:0]           req_dst;
  logic [NREQ-1:0][XLEN-1:0] req_data;
  logic                      rf_hold;
  logic                      rf_we;
  rsd_t                      rf_dst;
  logic [XLEN-1:0]           rf_dst_d;
  logic                      issue_valid;
  rsd_t                      issue_dst;
  logic                      issue_ready;
  rsd_t                      rd_src1, rd_src2;
  logic                      hazard1, hazard2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_dst_i     (req_dst),
    .req_data_i    (req_data),
    .rf_hold_i     (rf_hold),
    .rf_we_o       (rf_we),
    .rf_dst_o      (rf_dst),
    .rf_dst_d_o    (rf_dst_d),
    .issue_valid_i (issue_valid),
    .issue_dst_i   (issue_dst),
    .issue_ready_o (issue_ready),
    .rd_src1_i     (rd_src1),
    .rd_src2_i     (rd_src2),
    .hazard1_o     (hazard1),
    .hazard2_o     (hazard2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Advance one edge and land 1 time unit after it; inputs change here and
  // outputs are sampled after a further #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_write(input logic [31:0] dst, input logic [31:0] dat, input string tag);
    chk({tag, "_we"},  32'(rf_we),    32'd1);
    chk({tag, "_dst"}, 32'(rf_dst),   dst);
    chk({tag, "_dat"}, rf_dst_d,      dat);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_dst = '0; req_data = '0; rf_hold = 1'b0;
    issue_valid = 1'b0; issue_dst = zero; rd_src1 = zero; rd_src2 = zero;

    // Reset state
    step(); step();
    #1;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_dst", 32'(rf_dst), 32'd0);
    chk("rst_dat", rf_dst_d, 32'd0);
    chk("rst_haz", {30'd0, hazard2, hazard1}, 32'd0);
    chk("rst_iss_rdy", 32'(issue_ready), 32'd1);
    chk("rst_rdy", 32'(req_ready), 32'b111);
    rst_n = 1'b1;
    step();

    // Contention: ra, sp, gp issued, then all three sources at once
    issue_valid = 1'b1; issue_dst = ra; step();
    issue_dst = sp; step();
    issue_dst = gp; step();
    issue_valid = 1'b0; issue_dst = zero;
    req_valid = 3'b111;
    req_dst[0] = ra; req_data[0] = 32'h11;
    req_dst[1] = sp; req_data[1] = 32'h22;
    req_dst[2] = gp; req_data[2] = 32'h33;
    #1;
    chk("cnt_rdy0", 32'(req_ready), 32'b111);
    chk("cnt_we0", 32'(rf_we), 32'd0);
    step();
    req_valid = '0;
    #1;
    wr_write(32'd1, 32'h11, "cnt_w1");
    chk("cnt_rdy1", 32'(req_ready), 32'b001);
    step(); #1;
    wr_write(32'd2, 32'h22, "cnt_w2");
    chk("cnt_rdy2", 32'(req_ready), 32'b011);
    step(); #1;
    wr_write(32'd3, 32'h33, "cnt_w3");
    chk("cnt_rdy3", 32'(req_ready), 32'b111);
    step(); #1;
    chk("cnt_idle", 32'(rf_we), 32'd0);

    // Single write of t0 (x5) from EX
    issue_valid = 1'b1; issue_dst = t0; step();
    issue_valid = 1'b0; rd_src1 = t0;
    #1;
    chk("sw_haz_issue", 32'(hazard1), 32'd1);
    chk("sw_waw", 32'(issue_ready), 32'd0);
    req_valid[WB_EX] = 1'b1; req_dst[WB_EX] = t0; req_data[WB_EX] = 32'hDEADBEEF;
    #1;
    chk("sw_rdy", 32'(req_ready[WB_EX]), 32'd1);
    chk("sw_we_early", 32'(rf_we), 32'd0);
    step();
    req_valid = '0;
    #1;
    wr_write(32'd5, 32'hDEADBEEF, "sw_w");
    chk("sw_haz_buf", 32'(hazard1), 32'd1);
    step(); #1;
    chk("sw_we_after", 32'(rf_we), 32'd0);
    chk("sw_haz_after", 32'(hazard1), 32'd0);

    // Hold: t2 (x7) buffered by MDU while hold stays high
    issue_valid = 1'b1; issue_dst = t2; step();
    issue_valid = 1'b0; issue_dst = zero; rd_src1 = t2;
    rf_hold = 1'b1;
    req_valid[WB_MDU] = 1'b1; req_dst[WB_MDU] = t2; req_data[WB_MDU] = 32'h55;
    #1;
    chk("hd_rdy_fill", 32'(req_ready[WB_MDU]), 32'd1);
    step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("hd_we", 32'(rf_we), 32'd0);
      chk("hd_rdy", 32'(req_ready[WB_MDU]), 32'd0);
      chk("hd_haz", 32'(hazard1), 32'd1);
      step();
    end
    rf_hold = 1'b0;
    #1;
    wr_write(32'd7, 32'h55, "hd_w");
    chk("hd_rdy_rel", 32'(req_ready[WB_MDU]), 32'd1);
    step(); #1;
    chk("hd_done", 32'(rf_we), 32'd0);
    chk("hd_haz_clr", 32'(hazard1), 32'd0);

    // x0 drop from LSU
    rd_src1 = zero; rd_src2 = zero;
    req_valid[WB_LSU] = 1'b1; req_dst[WB_LSU] = zero; req_data[WB_LSU] = 32'hFFFFFFFF;
    #1;
    chk("x0_rdy", 32'(req_ready[WB_LSU]), 32'd1);
    step();
    req_valid = '0;
    #1;
    chk("x0_we1", 32'(rf_we), 32'd0);
    chk("x0_haz", {30'd0, hazard2, hazard1}, 32'd0);
    chk("x0_rdy_after", 32'(req_ready), 32'b111);
    step(); #1;
    chk("x0_we2", 32'(rf_we), 32'd0);

    // WAW on s1 (x9), then reissue the cycle the first write lands
    issue_valid = 1'b1; issue_dst = s1; step();
    rd_src1 = s1;
    req_valid[WB_EX] = 1'b1; req_dst[WB_EX] = s1; req_data[WB_EX] = 32'h99;
    #1;
    chk("waw_block", 32'(issue_ready), 32'd0);
    step();
    req_valid = '0;
    #1;
    wr_write(32'd9, 32'h99, "waw_w");
    chk("waw_block_commit", 32'(issue_ready), 32'd0);
    step(); #1;
    chk("waw_free", 32'(issue_ready), 32'd1);
    chk("waw_haz_gap", 32'(hazard1), 32'd0);
    step();
    issue_valid = 1'b0;
    #1;
    chk("waw_repend", 32'(hazard1), 32'd1);

    // Reset with two buffers full and pending = {x9, x8}
    issue_valid = 1'b1; issue_dst = s0; step();
    issue_valid = 1'b0; issue_dst = s1; rd_src2 = s0;
    rf_hold = 1'b1;
    req_valid = 3'b011;
    req_dst[0] = s0; req_data[0] = 32'h88;
    req_dst[1] = s1; req_data[1] = 32'h99;
    step();
    req_valid = '0;
    #1;
    chk("rm_hold_rdy", 32'(req_ready), 32'b100);
    chk("rm_pend", {30'd0, hazard2, hazard1}, 32'b11);
    rf_hold = 1'b0; rst_n = 1'b0;
    #1;
    chk("rm_we_in_rst", 32'(rf_we), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rm_we", 32'(rf_we), 32'd0);
    chk("rm_rdy", 32'(req_ready), 32'b111);
    chk("rm_haz", {30'd0, hazard2, hazard1}, 32'd0);
    chk("rm_iss_rdy", 32'(issue_ready), 32'd1);
    step(); #1;
    chk("rm_we_next", 32'(rf_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
